// File: rtl/receiver_uart_rx.sv
// UART receive path: 16x-oversampled deserialiser, FWFT word FIFO, sticky errors, config-request detect.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 majority sampling on ticks 7/8/9 of every bit.
module receiver_uart_rx #(
   parameter int unsigned RX_FIFO_DEPTH  = 8,
   parameter int unsigned CFG_REQ_CYCLES = 100000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       ov_baud_rt_i,
   input  logic       rx_i,
   input  logic [1:0] data_width_i,
   input  logic [1:0] stop_bits_number_i,
   input  logic [1:0] parity_mode_i,
   input  logic       rx_fifo_read_i,
   output logic [7:0] rx_data_o,
   output logic       rx_fifo_empty_o,
   output logic       rx_fifo_full_o,
   output logic       rx_done_o,
   output logic       parity_error_o,
   output logic       frame_error_o,
   output logic       overrun_error_o,
   input  logic       err_clear_i,
   output logic       cfg_req_o
);

   localparam int unsigned AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned LW = $clog2(CFG_REQ_CYCLES + 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_CFG_REQ
   } rx_state_e;

   rx_state_e         state_q;
   logic              rx_meta_q;
   logic              rxs_q;
   logic [3:0]        baud_cnt_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic              par_pend_q;
   logic              frm_pend_q;
   logic              stop2_q;
   logic [LW-1:0]     low_cnt_q;
   logic              rx_done_q;
   logic              cfg_req_q;
   logic              parity_error_q;
   logic              frame_error_q;
   logic              overrun_error_q;

   logic [7:0]        mem_q [RX_FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [7:0]        head_q, head_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;

   logic              sample_bit_c;
   logic              sample_tick_c;
   logic              last_bit_c;
   logic              two_stop_c;
   logic              cfg_hit_c;
   logic              frame_done_c;
   logic              frm_now_c;
   logic              pop_c;
   logic              push_c;
   logic              overrun_c;

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [3:0] START_PT = 4'd9;
   logic [1:0] vote_q;

   // Collect the two earlier samples of each bit; the third is the live line on the decision tick.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vote_q <= 2'b11;
      end else if (ov_baud_rt_i &&
                   (((state_q == RX_START) && ((baud_cnt_q == 4'd7) || (baud_cnt_q == 4'd8))) ||
                    (((state_q == RX_DATA) || (state_q == RX_PARITY) || (state_q == RX_STOP)) &&
                     ((baud_cnt_q == 4'd13) || (baud_cnt_q == 4'd14))))) begin
         vote_q <= {vote_q[0], rxs_q};
      end
   end

   assign sample_bit_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
`else
   localparam logic [3:0] START_PT = 4'd7;
   assign sample_bit_c = rxs_q;
`endif

   assign sample_tick_c = ov_baud_rt_i && (baud_cnt_q == 4'd15);
   assign last_bit_c    = (bit_cnt_q == (3'(data_width_i) + 3'd4));
   assign two_stop_c    = (stop_bits_number_i == 2'b01);
   assign cfg_hit_c     = !rxs_q && (low_cnt_q == LW'(CFG_REQ_CYCLES - 1));
   assign frame_done_c  = (state_q == RX_STOP) && sample_tick_c &&
                          !(two_stop_c && !stop2_q) && !cfg_hit_c;
   assign frm_now_c     = frm_pend_q | !sample_bit_c;
   assign pop_c         = rx_fifo_read_i && !empty_q;
   assign push_c        = frame_done_c && (!full_q || pop_c);
   assign overrun_c     = frame_done_c && full_q && !pop_c;

   // FIFO next state; the head register is preloaded so the output stays registered.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_c);
      rd_ptr_d = rd_ptr_q + AW'(pop_c);
      count_d  = count_q + CW'(push_c) - CW'(pop_c);
      empty_d  = (count_d == '0);
      full_d   = (count_d == CW'(RX_FIFO_DEPTH));
      head_d   = 8'h00;
      if (!empty_d) begin
         if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = shift_q;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   // Receiver FSM, line synchroniser, low-run counter, FIFO control and sticky errors.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= RX_IDLE;
         rx_meta_q       <= 1'b1;
         rxs_q           <= 1'b1;
         baud_cnt_q      <= 4'd0;
         bit_cnt_q       <= 3'd0;
         shift_q         <= 8'h00;
         par_pend_q      <= 1'b0;
         frm_pend_q      <= 1'b0;
         stop2_q         <= 1'b0;
         low_cnt_q       <= '0;
         rx_done_q       <= 1'b0;
         cfg_req_q       <= 1'b0;
         parity_error_q  <= 1'b0;
         frame_error_q   <= 1'b0;
         overrun_error_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         head_q          <= 8'h00;
         empty_q         <= 1'b1;
         full_q          <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rxs_q     <= rx_meta_q;
         rx_done_q <= frame_done_c;
         cfg_req_q <= 1'b0;

         if (rxs_q) begin
            low_cnt_q <= '0;
         end else if (low_cnt_q != LW'(CFG_REQ_CYCLES)) begin
            low_cnt_q <= low_cnt_q + LW'(1);
         end

         parity_error_q  <= (parity_error_q & ~err_clear_i) | (frame_done_c & par_pend_q);
         frame_error_q   <= (frame_error_q & ~err_clear_i) | (frame_done_c & frm_now_c);
         overrun_error_q <= (overrun_error_q & ~err_clear_i) | overrun_c;

         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         empty_q  <= empty_d;
         full_q   <= full_d;

         if (ov_baud_rt_i) begin
            baud_cnt_q <= baud_cnt_q + 4'd1;
         end

         if (cfg_hit_c) begin
            state_q   <= RX_CFG_REQ;
            cfg_req_q <= 1'b1;
            bit_cnt_q <= 3'd0;
            stop2_q   <= 1'b0;
         end else begin
            unique case (state_q)
               RX_IDLE: begin
                  if (!rxs_q && enable_i) begin
                     state_q    <= RX_START;
                     baud_cnt_q <= 4'd0;
                  end
               end
               RX_START: begin
                  if (ov_baud_rt_i && (baud_cnt_q == START_PT)) begin
                     if (!sample_bit_c) begin
                        state_q    <= RX_DATA;
                        baud_cnt_q <= 4'd0;
                        bit_cnt_q  <= 3'd0;
                        shift_q    <= 8'h00;
                        par_pend_q <= 1'b0;
                        frm_pend_q <= 1'b0;
                        stop2_q    <= 1'b0;
                     end else begin
                        state_q <= RX_IDLE;
                     end
                  end
               end
               RX_DATA: begin
                  if (sample_tick_c) begin
                     shift_q[bit_cnt_q] <= sample_bit_c;
                     bit_cnt_q          <= bit_cnt_q + 3'd1;
                     if (last_bit_c) begin
                        bit_cnt_q <= 3'd0;
                        state_q   <= parity_mode_i[1] ? RX_STOP : RX_PARITY;
                     end
                  end
               end
               RX_PARITY: begin
                  if (sample_tick_c) begin
                     par_pend_q <= (^shift_q) ^ sample_bit_c ^ parity_mode_i[0];
                     state_q    <= RX_STOP;
                  end
               end
               RX_STOP: begin
                  if (sample_tick_c) begin
                     if (two_stop_c && !stop2_q) begin
                        stop2_q    <= 1'b1;
                        frm_pend_q <= frm_now_c;
                     end else begin
                        stop2_q <= 1'b0;
                        state_q <= RX_IDLE;
                     end
                  end
               end
               RX_CFG_REQ: begin
                  if (rxs_q) begin
                     state_q <= RX_IDLE;
                  end
               end
               default: state_q <= RX_IDLE;
            endcase
         end
      end
   end

   assign rx_data_o       = head_q;
   assign rx_fifo_empty_o = empty_q;
   assign rx_fifo_full_o  = full_q;
   assign rx_done_o       = rx_done_q;
   assign parity_error_o  = parity_error_q;
   assign frame_error_o   = frame_error_q;
   assign overrun_error_o = overrun_error_q;
   assign cfg_req_o       = cfg_req_q;

endmodule

// File: doc/receiver_uart_rx.md
Name: receiver_uart_rx

Overview:
- Receive half of the UART controller; counterpart of the transmitter. Runs on the system clock and uses the shared 16x oversampling baud tick (ov_baud_rt_i).
- Deserialises frames from the rx line: start bit, 5-8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
- Buffers received words in an internal first-word-fall-through (FWFT) FIFO.
- Detects the master's configuration request: rx held low for CFG_REQ_CYCLES cycles.

Parameters:
- RX_FIFO_DEPTH, 8, FIFO depth in words; power of two, >=2.
- CFG_REQ_CYCLES, 100000, consecutive synchronised-low clk cycles that form a configuration request (1 ms at 100 MHz).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  when low, RX_IDLE does not accept a new start bit
- ov_baud_rt_i  in  1  16x baud tick, one clk wide
- rx_i  in  1  serial line, asynchronous
- data_width_i  in  2  0=5, 1=6, 2=7, 3=8 data bits
- stop_bits_number_i  in  2  2'b01 = two stop bits; all other codes = one
- parity_mode_i  in  2  bit1=1: no parity; bit1=0: bit0=0 even, bit0=1 odd
- rx_fifo_read_i  in  1  pop head word
- rx_data_o  out  8  FIFO head, right-aligned, unused MSBs zero
- rx_fifo_empty_o  out  1  FIFO empty
- rx_fifo_full_o  out  1  FIFO full
- rx_done_o  out  1  1-cycle pulse at end of every completed frame
- parity_error_o  out  1  sticky; parity mismatch
- frame_error_o  out  1  sticky; any stop bit sampled 0
- overrun_error_o  out  1  sticky; frame completed while FIFO full
- err_clear_i  in  1  clears all three sticky errors
- cfg_req_o  out  1  1-cycle pulse on configuration request detection

Behaviour:
- Reset values:
  - 2-flop synchroniser on rx_i resets to 1. All logic below uses the synchronised line rxs.
  - Outputs: rx_data_o=0, rx_fifo_empty_o=1, all others 0.
  - FSM in RX_IDLE; baud counter, bit counter and low counter all 0.
- Reset mid-frame: partial word discarded; FIFO contents discarded.
- Baud counter: 4 bits; advances only on ov_baud_rt_i.
- RX_IDLE:
  - rxs==0 and enable_i=1 -> RX_START, baud counter cleared.
- RX_START:
  - On the tick where counter==7: rxs==0 -> RX_DATA, counter=0. rxs==1 -> false start, back to RX_IDLE, nothing pushed.
- RX_DATA:
  - On the tick where counter==15: store rxs in bit[bit_count] and increment bit_count.
  - After the last bit: -> RX_PARITY if parity enabled, else -> RX_STOP.
- RX_PARITY:
  - On the tick where counter==15: error = XOR(data bits, parity bit) XOR parity_mode_i[0]; nonzero sets the pending parity flag.
  - -> RX_STOP.
- RX_STOP:
  - On the tick where counter==15: rxs==0 sets the pending frame flag.
  - If two stop bits are configured and this is the first, stay for a second bit period.
  - Otherwise frame complete; same cycle:
    - push the word if FIFO not full, else drop it and set overrun_error_o;
    - OR the pending flags into the sticky errors;
    - pulse rx_done_o;
    - -> RX_IDLE.
- Configuration inputs: sampled live. They must be held stable while the FSM is outside RX_IDLE.
- Configuration request detection:
  - Low counter increments every clk while rxs==0 and clears when rxs==1. It saturates.
  - When it reaches CFG_REQ_CYCLES (any state): abort the current frame (no push, no rx_done_o), pulse cfg_req_o once, -> RX_CFG_REQ.
  - RX_CFG_REQ: wait for rxs==1 -> RX_IDLE. No second pulse while the line stays low.
- FIFO (FWFT):
  - rx_data_o shows the head word whenever not empty.
  - Read while empty: ignored.
  - Push and read in the same cycle when full: both take effect; no overrun.
  - Pointers wrap modulo RX_FIFO_DEPTH.
- Sticky errors:
  - err_clear_i clears all three.
  - If err_clear_i and a new error event occur in the same cycle, the error is set (set wins).

Optional Feature:
- Macro: RX_MAJORITY_VOTE_EN.
- Defined: every sample point (start, data, parity, stop) uses the 2-of-3 majority of rxs captured on ticks 7, 8 and 9 (data/parity/stop counters offset accordingly). The decision is taken on tick 9.
- Undefined: single sample at the points above. No extra registers are present.

Test Plan:
- 8N1, 0xA5 sent LSB first -> one rx_done_o pulse; rx_data_o=0xA5; rx_fifo_empty_o falls; no errors set.
- 5E2, data 0x13 with correct even parity bit 1 -> rx_data_o=0x13. Same frame with parity bit 0 -> word pushed and parity_error_o=1 until err_clear_i.
- 8N1, stop bit driven 0 -> frame_error_o=1; word still pushed; rx_done_o pulses once.
- RX_FIFO_DEPTH=8, 9 frames 0x00..0x08 with no reads -> rx_fifo_full_o after the 8th frame; 9th frame dropped and overrun_error_o=1; 8 reads return 0x00..0x07.
- 1-tick (<8 ticks) low glitch on rx_i in RX_IDLE -> false start; FSM back in RX_IDLE; no push, no rx_done_o.
- rx_i held low 2*CFG_REQ_CYCLES starting mid-frame -> exactly one cfg_req_o pulse; partial frame discarded. rx_i high then a valid 0x3C frame -> received normally.
